// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control path.
// The state numbering is visible on state_dbg, so keep it stable.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAddr = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StRExec   = 4'd6,
      StRWb     = 4'd7,
      StBranch  = 4'd8,
      StJump    = 4'd9,
      StIExec   = 4'd10,
      StIWb     = 4'd11
   } state_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpSlti  = 6'b001010;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;

   localparam logic [1:0] AluAdd   = 2'b00;
   localparam logic [1:0] AluSub   = 2'b01;
   localparam logic [1:0] AluFunct = 2'b10;
   localparam logic [1:0] AluImm   = 2'b11;

   localparam logic [1:0] SrcBRt    = 2'b00;
   localparam logic [1:0] SrcBFour  = 2'b01;
   localparam logic [1:0] SrcBImm   = 2'b10;
   localparam logic [1:0] SrcBImmSh = 2'b11;

   localparam logic [1:0] PcAlu    = 2'b00;
   localparam logic [1:0] PcAluOut = 2'b01;
   localparam logic [1:0] PcJump   = 2'b10;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_write;
      logic       pc_en;
      logic [1:0] pc_source;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       instr_done;
      logic       illegal;
   } ctrl_t;

   function automatic logic is_legal(input logic [5:0] op);
      case (op)
         OpRtype, OpLw, OpSw, OpBeq, OpBne, OpJ,
         OpAddi, OpSlti, OpAndi, OpOri: return 1'b1;
         default:                      return 1'b0;
      endcase
   endfunction

   // Logical immediates are zero-extended; everything else sign-extends.
   function automatic logic sign_ext(input logic [5:0] op);
      return !((op == OpAndi) || (op == OpOri));
   endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state-to-control decode. Moore outputs except for the
// mem_ack qualification of request states and the branch condition.
module mips_ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  state_e     state,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ack,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         StFetch: begin
            ctrl.mem_req   = 1'b1;
            ctrl.alu_src_b = SrcBFour;
            ctrl.alu_op    = AluAdd;
            ctrl.pc_source = PcAlu;
            ctrl.ir_write  = mem_ack;
            ctrl.pc_en     = mem_ack;
         end
         StDecode: begin
            // Branch target is precomputed into ALUOut here.
            ctrl.alu_src_b = SrcBImmSh;
            ctrl.alu_op    = AluAdd;
            if (!is_legal(opcode)) begin
               ctrl.illegal    = 1'b1;
               ctrl.instr_done = 1'b1;
            end
         end
         StMemAddr: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBImm;
            ctrl.alu_op    = AluAdd;
         end
         StMemRd: begin
            ctrl.mem_req = 1'b1;
            ctrl.iord    = 1'b1;
         end
         StMemWb: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         StMemWr: begin
            ctrl.mem_req    = 1'b1;
            ctrl.iord       = 1'b1;
            ctrl.mem_we     = 1'b1;
            ctrl.instr_done = mem_ack;
         end
         StRExec: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBRt;
            ctrl.alu_op    = AluFunct;
         end
         StRWb: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         StBranch: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SrcBRt;
            ctrl.alu_op     = AluSub;
            ctrl.pc_source  = PcAluOut;
            ctrl.pc_en      = (opcode == OpBne) ? ~zero : zero;
            ctrl.instr_done = 1'b1;
         end
         StJump: begin
            ctrl.pc_source  = PcJump;
            ctrl.pc_en      = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         StIExec: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBImm;
            ctrl.alu_op    = AluImm;
         end
         StIWb: begin
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM: sequences fetch through writeback over a
// shared req/ack memory port and counts retired instructions.
module mips_mc_control
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_write,
   output logic             pc_en,
   output logic [1:0]       pc_source,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             ext_op,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             instr_done,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count,
   output logic [3:0]       state_dbg
);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ext_q;
   ctrl_t            ctrl;
   ctrl_t            ctrl_g;

   // funct is consumed by the shared ALU decoder, not here.
   logic unused_funct;
   assign unused_funct = ^funct;

   mips_ctrl_decode u_decode (
      .state   (state_q),
      .opcode  (opcode),
      .zero    (zero),
      .mem_ack (mem_ack),
      .ctrl    (ctrl)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StFetch;
         cnt_q   <= '0;
         ext_q   <= 1'b1;
      end else begin
         if (ctrl.instr_done) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         case (state_q)
            StFetch: if (mem_ack) state_q <= StDecode;
            StDecode: begin
               ext_q <= sign_ext(opcode);
               case (opcode)
                  OpLw, OpSw:                      state_q <= StMemAddr;
                  OpRtype:                         state_q <= StRExec;
                  OpBeq, OpBne:                    state_q <= StBranch;
                  OpJ:                             state_q <= StJump;
                  OpAddi, OpSlti, OpAndi, OpOri:   state_q <= StIExec;
                  default:                         state_q <= StFetch;
               endcase
            end
            StMemAddr: state_q <= (opcode == OpSw) ? StMemWr : StMemRd;
            StMemRd:   if (mem_ack) state_q <= StMemWb;
            StMemWr:   if (mem_ack) state_q <= StFetch;
            StRExec:   state_q <= StRWb;
            StIExec:   state_q <= StIWb;
            default:   state_q <= StFetch;
         endcase
      end
   end

   // Reset forces every control line low so an aborted instruction has no effect.
   assign ctrl_g = rst_n ? ctrl : '0;

   assign mem_req     = ctrl_g.mem_req;
   assign mem_we      = ctrl_g.mem_we;
   assign iord        = ctrl_g.iord;
   assign ir_write    = ctrl_g.ir_write;
   assign pc_en       = ctrl_g.pc_en;
   assign pc_source   = ctrl_g.pc_source;
   assign alu_src_a   = ctrl_g.alu_src_a;
   assign alu_src_b   = ctrl_g.alu_src_b;
   assign alu_op      = ctrl_g.alu_op;
   assign reg_dst     = ctrl_g.reg_dst;
   assign mem_to_reg  = ctrl_g.mem_to_reg;
   assign reg_write   = ctrl_g.reg_write;
   assign instr_done  = ctrl_g.instr_done;
   assign illegal     = ctrl_g.illegal;
   assign instr_count = rst_n ? cnt_q : '0;
   assign state_dbg   = rst_n ? state_q : 4'd0;

   // The new extension mode is already visible in DECODE, then held from the register.
   assign ext_op = (rst_n && state_q == StDecode) ? sign_ext(opcode) : ext_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: per-cycle expected control vectors are
// queued per instruction and compared as the FSM steps through its states.
module tb_mips_mc_control;

   localparam int CW = 4;

   logic          clk, rst_n, zero, mem_ack;
   logic [5:0]    opcode, funct;
   logic          mem_req, mem_we, iord, ir_write, pc_en, alu_src_a, ext_op;
   logic          reg_dst, mem_to_reg, reg_write, instr_done, illegal;
   logic [1:0]    pc_source, alu_src_b, alu_op;
   logic [CW-1:0] instr_count;
   logic [3:0]    state_dbg;

   typedef struct packed {
      logic [3:0] st;
      logic       mem_req, mem_we, iord, ir_write, pc_en;
      logic [1:0] pc_source;
      logic       alu_src_a;
      logic [1:0] alu_src_b, alu_op;
      logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal;
   } exp_t;

   typedef struct {
      exp_t e;
      logic ack;
      logic ext;
   } item_t;

   item_t      sb[$];
   exp_t       got;
   int         checks = 0;
   int         errors = 0;
   int         exp_cnt = 0;
   logic [5:0] cur_op;
   logic       cur_z;

   mips_mc_control #(.CNT_W(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode      (opcode),
      .funct       (funct),
      .zero        (zero),
      .mem_ack     (mem_ack),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .iord        (iord),
      .ir_write    (ir_write),
      .pc_en       (pc_en),
      .pc_source   (pc_source),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .alu_op      (alu_op),
      .ext_op      (ext_op),
      .reg_dst     (reg_dst),
      .mem_to_reg  (mem_to_reg),
      .reg_write   (reg_write),
      .instr_done  (instr_done),
      .illegal     (illegal),
      .instr_count (instr_count),
      .state_dbg   (state_dbg)
   );

   assign got = {state_dbg, mem_req, mem_we, iord, ir_write, pc_en, pc_source, alu_src_a,
                 alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, instr_done, illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish, expected finish before 100000");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // State following DECODE for a given opcode; 0 means unsupported.
   function automatic logic [3:0] after_decode(input logic [5:0] op);
      case (op)
         6'b100011, 6'b101011:                       return 4'd2;
         6'b000000:                                  return 4'd6;
         6'b000100, 6'b000101:                       return 4'd8;
         6'b000010:                                  return 4'd9;
         6'b001000, 6'b001010, 6'b001100, 6'b001101: return 4'd10;
         default:                                    return 4'd0;
      endcase
   endfunction

   function automatic exp_t model(input logic [3:0] st, input logic [5:0] op,
                                  input logic ack, input logic z);
      exp_t e;
      e = '0;
      e.st = st;
      case (st)
         4'd0: begin e.mem_req = 1; e.alu_src_b = 2'b01; e.ir_write = ack; e.pc_en = ack; end
         4'd1: begin
            e.alu_src_b = 2'b11;
            if (after_decode(op) == 4'd0) begin e.illegal = 1; e.instr_done = 1; end
         end
         4'd2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
         4'd3:  begin e.mem_req = 1; e.iord = 1; end
         4'd4:  begin e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1; end
         4'd5:  begin e.mem_req = 1; e.iord = 1; e.mem_we = 1; e.instr_done = ack; end
         4'd6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
         4'd7:  begin e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1; end
         4'd8:  begin
            e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_source = 2'b01; e.instr_done = 1;
            e.pc_en = (op == 6'b000101) ? ~z : z;
         end
         4'd9:  begin e.pc_source = 2'b10; e.pc_en = 1; e.instr_done = 1; end
         4'd10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b11; end
         4'd11: begin e.reg_write = 1; e.instr_done = 1; end
         default: ;
      endcase
      return e;
   endfunction

   task automatic push(input logic [3:0] st, input logic ack);
      item_t it;
      it.e   = model(st, cur_op, ack, cur_z);
      it.ack = ack;
      it.ext = !((cur_op == 6'b001100) || (cur_op == 6'b001101));
      sb.push_back(it);
   endtask

   // fw/mw: wait cycles (mem_ack low) in FETCH and in MEM_RD/MEM_WR.
   task automatic run_instr(input string name, input logic [5:0] op, input int fw,
                            input int mw, input logic z);
      item_t      it;
      logic [3:0] nxt;
      logic [3:0] mst;
      cur_op = op;
      cur_z  = z;
      for (int i = 0; i < fw; i++) push(4'd0, 1'b0);
      push(4'd0, 1'b1);
      push(4'd1, 1'b1);
      nxt = after_decode(op);
      case (nxt)
         4'd2: begin
            mst = (op == 6'b101011) ? 4'd5 : 4'd3;
            push(4'd2, 1'b1);
            for (int i = 0; i < mw; i++) push(mst, 1'b0);
            push(mst, 1'b1);
            if (mst == 4'd3) push(4'd4, 1'b1);
         end
         4'd6:  begin push(4'd6, 1'b1); push(4'd7, 1'b1); end
         4'd8:  push(4'd8, 1'b1);
         4'd9:  push(4'd9, 1'b1);
         4'd10: begin push(4'd10, 1'b1); push(4'd11, 1'b1); end
         default: ;
      endcase
      opcode = op;
      zero   = z;
      while (sb.size() > 0) begin
         it = sb.pop_front();
         @(negedge clk);
         mem_ack = it.ack;
         #1;
         check($sformatf("%s_st%0d_ctrl", name, it.e.st), 32'(got), 32'(it.e));
         if (it.e.st != 4'd0) check($sformatf("%s_st%0d_ext_op", name, it.e.st),
                                    32'(ext_op), 32'(it.ext));
      end
      exp_cnt = (exp_cnt + 1) % (1 << CW);
      @(posedge clk);
      #1;
      check($sformatf("%s_instr_count", name), 32'(instr_count), 32'(exp_cnt));
      check($sformatf("%s_back_to_fetch", name), 32'(state_dbg), 32'd0);
   endtask

   initial begin
      int k;
      rst_n   = 1'b0;
      opcode  = 6'b0;
      funct   = 6'b100000;
      zero    = 1'b0;
      mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("por_outputs", 32'(got), 32'd0);
      rst_n = 1'b1;
      #1;
      check("por_state", 32'(state_dbg), 32'd0);
      check("por_count", 32'(instr_count), 32'd0);
      check("por_ext_op", 32'(ext_op), 32'd1);

      // Start an lw and park it in MEM_RD, then reset it away.
      opcode  = 6'b100011;
      mem_ack = 1'b1;
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      k = 0;
      while (state_dbg != 4'd3 && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("reach_mem_rd", 32'(state_dbg), 32'd3);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_rd_outputs_a", 32'(got), 32'd0);
      @(negedge clk);
      mem_ack = 1'b1;
      #1;
      check("rst_mid_rd_outputs_b", 32'(got), 32'd0);
      check("rst_mid_rd_count", 32'(instr_count), 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      mem_ack = 1'b0;
      #1;
      check("rst_release_state", 32'(state_dbg), 32'd0);
      check("rst_release_count", 32'(instr_count), 32'd0);
      check("rst_release_ext_op", 32'(ext_op), 32'd1);
      check("rst_release_mem_req", 32'(mem_req), 32'd1);
      exp_cnt = 0;

      run_instr("add",    6'b000000, 0, 0, 1'b0);
      run_instr("lw",     6'b100011, 3, 2, 1'b0);
      run_instr("beq_z1", 6'b000100, 0, 0, 1'b1);
      run_instr("bne_z1", 6'b000101, 0, 0, 1'b1);
      run_instr("ori",    6'b001101, 0, 0, 1'b0);
      run_instr("addi",   6'b001000, 0, 0, 1'b0);
      run_instr("sw",     6'b101011, 1, 1, 1'b1);
      run_instr("andi",   6'b001100, 2, 0, 1'b0);
      run_instr("j",      6'b000010, 0, 0, 1'b1);
      run_instr("slti",   6'b001010, 0, 0, 1'b0);
      run_instr("rtype",  6'b000000, 1, 0, 1'b1);
      run_instr("beq_z0", 6'b000100, 0, 0, 1'b0);
      run_instr("bne_z0", 6'b000101, 0, 0, 1'b0);
      run_instr("lw_fast",6'b100011, 0, 0, 1'b0);
      run_instr("j2",     6'b000010, 0, 0, 1'b0);
      // Sixteenth retirement wraps the 4-bit counter to zero.
      run_instr("illegal",6'b111111, 0, 0, 1'b0);
      check("wrap_count_zero", 32'(instr_count), 32'd0);
      run_instr("add_after_wrap", 6'b000000, 0, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
Multi-cycle control FSM for the MIPS core. It sequences fetch, decode, execute, memory and writeback over a shared instruction/data memory port using a req/ack handshake. It drives every datapath select, including ext_op, which sets sign- vs zero-extension of the 16-bit immediate. It also counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active low
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]; reserved, not decoded in this revision (ALU decoder uses it)
- zero  in  1  ALU zero flag
- mem_ack  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load the IR
- pc_en  out  1  PC load enable; branch condition already applied
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 extended immediate, 11 extended immediate << 2
- alu_op  out  2  00 add, 01 sub, 10 funct, 11 immediate-op
- ext_op  out  1  1 = sign-extend, 0 = zero-extend
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- reg_write  out  1  register-file write enable
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode
- instr_count  out  CNT_W  retired-instruction count
- state_dbg  out  4  current state encoding

Behaviour:
- Reset: when rst_n = 0 at a clk edge:
  - state becomes FETCH; instr_count becomes 0; ext_op register becomes 1.
  - While rst_n = 0, all other outputs are forced to 0.
  - Reset mid-instruction aborts it: no reg_write, pc_en or mem_req in the following cycle.
- Outputs are a Moore decode of state, with three exceptions gated by mem_ack or zero:
  - FETCH advances ir_write and pc_en only on mem_ack.
  - MEM_RD and MEM_WR advance only on mem_ack.
  - pc_en in BRANCH depends on zero.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addi 001000, slti 001010, andi 001100, ori 001101.
- FETCH:
  - Drives mem_req=1, mem_we=0, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - Holds while mem_ack=0, with ir_write=0 and pc_en=0.
  - On mem_ack: ir_write=1 and pc_en=1, then go to DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Registers ext_op: 0 for andi/ori, 1 otherwise.
  - Next state by opcode: lw/sw -> MEM_ADDR; R -> R_EXEC; beq/bne -> BRANCH; j -> JUMP; addi/slti/andi/ori -> I_EXEC.
  - Any other opcode: illegal=1, instr_done=1, then FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD: mem_req=1, iord=1, mem_we=0. Holds until mem_ack, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1, then FETCH.
- MEM_WR: mem_req=1, iord=1, mem_we=1. On mem_ack: instr_done=1, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10, then R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1, then FETCH.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01.
  - pc_en = zero for beq, ~zero for bne.
  - instr_done=1, then FETCH.
- JUMP: pc_source=10, pc_en=1, instr_done=1, then FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11, then I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1, then FETCH.
- ext_op register:
  - Changes only in DECODE; holds its value through the end of the instruction.
  - Its value in FETCH is irrelevant.
- instr_count:
  - Increments on every instr_done, including illegal opcodes.
  - Wraps from all-ones to 0 without a flag.
- Latency without wait states: R/I-type 4 cycles; lw 5; sw 4; beq/bne/j 3.
  - Each mem_ack=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_ack outside a request state is ignored.
- mem_req stays asserted and stable until the ack cycle.
- The state register has no unreachable-state recovery other than reset.
  - Undefined encodings decode to FETCH next with all outputs 0.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state enum, 4-bit encoding FETCH=0 … I_WB=11;
  - opcode localparams;
  - alu_op, alu_src_b and pc_source encodings.
- The ALU decoder that consumes alu_op/funct is shared.
- One natural sub-module: mips_ctrl_decode, a combinational state-to-output decode. The FSM and counter stay in the top.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles in mid-MEM_RD -> all outputs 0; state_dbg=0 after the edge; instr_count=0; ext_op=1.
- add, R-type opcode 000000, mem_ack every request cycle:
  - ir_write at cycle 1 and reg_write with reg_dst=1 at cycle 4;
  - instr_done at cycle 4; instr_count=1.
- lw with mem_ack delayed 3 cycles in FETCH and 2 in MEM_RD:
  - mem_req held high with iord 0 then 1;
  - reg_write with mem_to_reg=1 at cycle 10.
- beq with zero=1, then bne with zero=1:
  - pc_en=1, pc_source=01 in BRANCH for beq;
  - pc_en=0 in BRANCH for bne;
  - each instruction takes 3 cycles.
- ori (001101) then addi (001000) -> ext_op=0 from DECODE through I_WB, then ext_op=1 for addi.
- Opcode 111111 -> illegal and instr_done pulse in DECODE; back to FETCH. Preload counter to all-ones -> instr_count wraps to 0.
